// File: rtl/lcd_stream_drive_if.sv
// LCD panel drive controller with an AHB-Lite register slave.
// Generates VSYNC/HSYNC/DE timing for a programmable frame and pulls
// pixels from a valid/ready stream, PPC pixels per beat.
// Optional feature macro: LCD_DRIVE_BR_EN adds a saturating brightness
// stage (registers 8/9) and one extra pipeline stage on all timing outputs.
module lcd_stream_drive_if #(
  parameter int W_ADDR      = 32,
  parameter int W_DATA      = 32,
  parameter int W_WB_DATA   = 2,
  parameter int IMG_PIX_W   = 8,
  parameter int PPC         = 2,
  parameter int W_SIZE      = 12,
  parameter int W_DELAY     = 12,
  parameter int WIDTH       = 768,
  parameter int HEIGHT      = 512,
  parameter int VSYNC_DELAY = 100,
  parameter int HSYNC_DELAY = 160,
  parameter int FRAME_GAP   = 200
) (
  input  logic                         HCLK,
  input  logic                         HRESETn,
  input  logic                         sl_HSEL,
  input  logic                         sl_HREADY,
  input  logic                         sl_HWRITE,
  input  logic [1:0]                   sl_HTRANS,
  input  logic [2:0]                   sl_HBURST,
  input  logic [2:0]                   sl_HSIZE,
  input  logic [W_ADDR-1:0]            sl_HADDR,
  input  logic [W_DATA-1:0]            sl_HWDATA,
  output logic                         out_sl_HREADY,
  output logic [1:0]                   out_sl_HRESP,
  output logic [W_DATA-1:0]            out_sl_HRDATA,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [PPC*3*IMG_PIX_W-1:0]   in_data,
  output logic                         out_vsync,
  output logic                         out_hsync,
  output logic                         out_de,
  output logic [PPC*3*IMG_PIX_W-1:0]   out_data,
  output logic [W_SIZE-1:0]            out_row,
  output logic [W_SIZE-1:0]            out_col,
  output logic                         irq
);
  localparam int DW = PPC*3*IMG_PIX_W;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_VSYNC = 3'd1, ST_HSYNC = 3'd2,
                         ST_DATA = 3'd3, ST_GAP = 3'd4;

  logic [3:0]          addr_reg;
  logic                wr_reg;
  logic [W_SIZE-1:0]   width_reg, height_reg, row_reg, col_reg, row_next, col_next;
  logic [W_DELAY-1:0]  vsync_delay_reg, hsync_delay_reg, frame_gap_reg;
  logic [W_DELAY-1:0]  cnt_reg, cnt_next, cur_delay;
  logic                start_reg, cont_reg, irq_en_reg, underflow_reg, frame_done_reg;
  logic [15:0]         frame_cnt_reg;
  logic [2:0]          state_reg, state_next;
  logic                ctrl_wr, status_wr, abort_pulse, start_eff, clr_start;
  logic                delay_done, fire, line_end, last_row, frame_end;
  logic                p1_vs, p1_hs, p1_de;
  logic [DW-1:0]       p1_data;
  logic [W_SIZE-1:0]   p1_row, p1_col;
  logic                unused_ok;

  assign unused_ok     = ^{sl_HBURST, sl_HSIZE, sl_HADDR, sl_HWDATA};
  assign out_sl_HREADY = 1'b1;
  assign out_sl_HRESP  = 2'b00;

  // Capture the AHB address phase of NONSEQ/SEQ transfers
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_reg <= '0;
      wr_reg   <= 1'b0;
    end else if (sl_HSEL && sl_HREADY && sl_HTRANS[1]) begin
      addr_reg <= sl_HADDR[W_WB_DATA+3:W_WB_DATA];
      wr_reg   <= sl_HWRITE;
    end else begin
      wr_reg   <= 1'b0;
    end
  end

  assign ctrl_wr     = wr_reg && (addr_reg == 4'd5);
  assign status_wr   = wr_reg && (addr_reg == 4'd6);
  assign abort_pulse = ctrl_wr && sl_HWDATA[3];
  // A start written this cycle is acted on immediately by the FSM
  assign start_eff   = ctrl_wr ? sl_HWDATA[0] : start_reg;

  assign cur_delay  = (state_reg == ST_VSYNC) ? vsync_delay_reg :
                      (state_reg == ST_HSYNC) ? hsync_delay_reg : frame_gap_reg;
  // Zero delays still occupy one cycle
  assign delay_done = ({1'b0, cnt_reg} + (W_DELAY+1)'(1)) >= {1'b0, cur_delay};
  assign fire       = (state_reg == ST_DATA) && in_valid;
  assign line_end   = ({1'b0, col_reg} + (W_SIZE+1)'(PPC)) >= {1'b0, width_reg};
  assign last_row   = ({1'b0, row_reg} + (W_SIZE+1)'(1)) >= {1'b0, height_reg};
  assign frame_end  = fire && line_end && last_row;
  assign clr_start  = abort_pulse ||
                      ((state_reg == ST_GAP) && delay_done && !(cont_reg && start_eff));
  assign in_ready   = (state_reg == ST_DATA);
  assign irq        = irq_en_reg && (underflow_reg || frame_done_reg);

  // Register file writes, sticky status and frame counting
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      width_reg       <= W_SIZE'(WIDTH);
      height_reg      <= W_SIZE'(HEIGHT);
      vsync_delay_reg <= W_DELAY'(VSYNC_DELAY);
      hsync_delay_reg <= W_DELAY'(HSYNC_DELAY);
      frame_gap_reg   <= W_DELAY'(FRAME_GAP);
      start_reg       <= 1'b0;
      cont_reg        <= 1'b0;
      irq_en_reg      <= 1'b0;
      underflow_reg   <= 1'b0;
      frame_done_reg  <= 1'b0;
      frame_cnt_reg   <= '0;
    end else begin
      if (wr_reg && addr_reg == 4'd0) width_reg       <= sl_HWDATA[W_SIZE-1:0];
      if (wr_reg && addr_reg == 4'd1) height_reg      <= sl_HWDATA[W_SIZE-1:0];
      if (wr_reg && addr_reg == 4'd2) vsync_delay_reg <= sl_HWDATA[W_DELAY-1:0];
      if (wr_reg && addr_reg == 4'd3) hsync_delay_reg <= sl_HWDATA[W_DELAY-1:0];
      if (wr_reg && addr_reg == 4'd4) frame_gap_reg   <= sl_HWDATA[W_DELAY-1:0];
      if (ctrl_wr) begin
        cont_reg   <= sl_HWDATA[1];
        irq_en_reg <= sl_HWDATA[2];
      end
      start_reg <= clr_start ? 1'b0 : start_eff;
      // Set events are placed after W1C so a coinciding set wins
      if (status_wr && sl_HWDATA[1]) underflow_reg  <= 1'b0;
      if (status_wr && sl_HWDATA[2]) frame_done_reg <= 1'b0;
      if ((state_reg == ST_DATA) && !in_valid) underflow_reg <= 1'b1;
      if (frame_end) begin
        frame_done_reg <= 1'b1;
        frame_cnt_reg  <= frame_cnt_reg + 16'd1;
      end
    end
  end

  // Frame timing state machine next-state logic
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    row_next   = row_reg;
    col_next   = col_reg;
    case (state_reg)
      ST_IDLE: if (start_eff) begin
        state_next = ST_VSYNC;
        cnt_next   = '0;
      end
      ST_VSYNC, ST_HSYNC: begin
        if (delay_done) begin
          state_next = (state_reg == ST_VSYNC) ? ST_HSYNC : ST_DATA;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + W_DELAY'(1);
        end
      end
      ST_DATA: if (in_valid) begin
        if (line_end) begin
          col_next   = '0;
          cnt_next   = '0;
          row_next   = last_row ? '0 : row_reg + W_SIZE'(1);
          state_next = last_row ? ST_GAP : ST_HSYNC;
        end else begin
          col_next = col_reg + W_SIZE'(PPC);
        end
      end
      ST_GAP: begin
        if (delay_done) begin
          cnt_next   = '0;
          state_next = (cont_reg && start_eff) ? ST_VSYNC : ST_IDLE;
        end else begin
          cnt_next = cnt_reg + W_DELAY'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (abort_pulse) begin
      state_next = ST_IDLE;
      cnt_next   = '0;
      row_next   = '0;
      col_next   = '0;
    end
  end

  // Frame timing state machine registers
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      row_reg   <= '0;
      col_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      row_reg   <= row_next;
      col_reg   <= col_next;
    end
  end

  // First output stage: timing flags and the accepted beat
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      p1_vs   <= 1'b0;
      p1_hs   <= 1'b0;
      p1_de   <= 1'b0;
      p1_data <= '0;
      p1_row  <= '0;
      p1_col  <= '0;
    end else begin
      p1_vs   <= (state_reg == ST_VSYNC);
      p1_hs   <= (state_reg == ST_HSYNC);
      p1_de   <= fire;
      p1_data <= fire ? in_data : '0;
      if (fire) begin
        p1_row <= row_reg;
        p1_col <= col_reg;
      end
    end
  end

`ifdef LCD_DRIVE_BR_EN
  logic                 br_mode_reg;
  logic [IMG_PIX_W-1:0] br_value_reg;
  logic [DW-1:0]        br_data;
  logic                 p2_vs, p2_hs, p2_de;
  logic [DW-1:0]        p2_data;
  logic [W_SIZE-1:0]    p2_row, p2_col;

  // Brightness registers
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      br_mode_reg  <= 1'b0;
      br_value_reg <= '0;
    end else begin
      if (wr_reg && addr_reg == 4'd8) br_mode_reg  <= sl_HWDATA[0];
      if (wr_reg && addr_reg == 4'd9) br_value_reg <= sl_HWDATA[IMG_PIX_W-1:0];
    end
  end

  // Saturating add/subtract per channel; the extra MSB is carry or borrow
  for (genvar gi = 0; gi < PPC*3; gi++) begin : g_br
    logic [IMG_PIX_W-1:0] ch;
    logic [IMG_PIX_W:0]   sum;
    assign ch  = p1_data[gi*IMG_PIX_W +: IMG_PIX_W];
    assign sum = br_mode_reg ? ({1'b0, ch} - {1'b0, br_value_reg})
                             : ({1'b0, ch} + {1'b0, br_value_reg});
    assign br_data[gi*IMG_PIX_W +: IMG_PIX_W] =
      sum[IMG_PIX_W] ? (br_mode_reg ? '0 : '1) : sum[IMG_PIX_W-1:0];
  end

  // Second output stage keeps every timing output aligned with the adjusted pixels
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      p2_vs   <= 1'b0;
      p2_hs   <= 1'b0;
      p2_de   <= 1'b0;
      p2_data <= '0;
      p2_row  <= '0;
      p2_col  <= '0;
    end else begin
      p2_vs   <= p1_vs;
      p2_hs   <= p1_hs;
      p2_de   <= p1_de;
      p2_data <= p1_de ? br_data : '0;
      p2_row  <= p1_row;
      p2_col  <= p1_col;
    end
  end

  assign out_vsync = p2_vs;
  assign out_hsync = p2_hs;
  assign out_de    = p2_de;
  assign out_data  = p2_data;
  assign out_row   = p2_row;
  assign out_col   = p2_col;
`else
  assign out_vsync = p1_vs;
  assign out_hsync = p1_hs;
  assign out_de    = p1_de;
  assign out_data  = p1_data;
  assign out_row   = p1_row;
  assign out_col   = p1_col;
`endif

  // Read mux from the captured register index
  always_comb begin
    out_sl_HRDATA = '0;
    case (addr_reg)
      4'd0: out_sl_HRDATA[W_SIZE-1:0]  = width_reg;
      4'd1: out_sl_HRDATA[W_SIZE-1:0]  = height_reg;
      4'd2: out_sl_HRDATA[W_DELAY-1:0] = vsync_delay_reg;
      4'd3: out_sl_HRDATA[W_DELAY-1:0] = hsync_delay_reg;
      4'd4: out_sl_HRDATA[W_DELAY-1:0] = frame_gap_reg;
      4'd5: out_sl_HRDATA[2:0] = {irq_en_reg, cont_reg, start_reg};
      4'd6: out_sl_HRDATA[2:0] = {frame_done_reg, underflow_reg, state_reg != ST_IDLE};
      4'd7: out_sl_HRDATA[15:0] = frame_cnt_reg;
`ifdef LCD_DRIVE_BR_EN
      4'd8: out_sl_HRDATA[0] = br_mode_reg;
      4'd9: out_sl_HRDATA[IMG_PIX_W-1:0] = br_value_reg;
`endif
      default: out_sl_HRDATA = '0;
    endcase
  end
endmodule

// File: tb/tb_lcd_stream_drive_if.sv
// Self-checking bench for lcd_stream_drive_if: a frame-timeline model
// predicts every output cycle; register checks pin status and counters.
module tb_lcd_stream_drive_if;
  localparam int PPC = 2, PW = 8, DW = PPC*3*PW, MAXC = 16384;
`ifdef LCD_DRIVE_BR_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic HCLK = 1'b0, HRESETn = 1'b0;
  logic sl_HSEL = 0, sl_HREADY = 1, sl_HWRITE = 0;
  logic [1:0] sl_HTRANS = 0;
  logic [2:0] sl_HBURST = 0, sl_HSIZE = 3'd2;
  logic [31:0] sl_HADDR = 0, sl_HWDATA = 0;
  logic out_sl_HREADY;
  logic [1:0] out_sl_HRESP;
  logic [31:0] out_sl_HRDATA;
  logic in_valid = 0, in_ready;
  logic [DW-1:0] in_data = '0, out_data;
  logic out_vsync, out_hsync, out_de, irq;
  logic [11:0] out_row, out_col;

  always #5 HCLK = ~HCLK;

  lcd_stream_drive_if dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .sl_HSEL(sl_HSEL), .sl_HREADY(sl_HREADY), .sl_HWRITE(sl_HWRITE),
    .sl_HTRANS(sl_HTRANS), .sl_HBURST(sl_HBURST), .sl_HSIZE(sl_HSIZE),
    .sl_HADDR(sl_HADDR), .sl_HWDATA(sl_HWDATA),
    .out_sl_HREADY(out_sl_HREADY), .out_sl_HRESP(out_sl_HRESP), .out_sl_HRDATA(out_sl_HRDATA),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_vsync(out_vsync), .out_hsync(out_hsync), .out_de(out_de),
    .out_data(out_data), .out_row(out_row), .out_col(out_col), .irq(irq)
  );

  int compared = 0, mismatched = 0;
  int cyc = 0, vs_seen = 0;
  bit chk_en = 0;
  bit exp_vs[MAXC], exp_hs[MAXC], exp_de[MAXC], exp_rdy[MAXC];
  logic [11:0] exp_row[MAXC], exp_col[MAXC];
  logic [DW-1:0] exp_dat[MAXC];
  bit vpat[MAXC];
  logic [DW-1:0] dpat[MAXC];
  int cfg_w, cfg_h, cfg_v, cfg_hs, cfg_g;
  int fcnt_m = 0, br_mode_m = 0, br_val_m = 0;
  bit uf_m = 0, fd_m = 0;

  // Per-cycle comparison of every panel output against the planned timeline
  always @(negedge HCLK) begin
    if (chk_en) begin
      compared++;
      if (out_vsync !== exp_vs[cyc] || out_hsync !== exp_hs[cyc] || out_de !== exp_de[cyc] ||
          in_ready !== exp_rdy[cyc] ||
          (exp_de[cyc] && (out_row !== exp_row[cyc] || out_col !== exp_col[cyc] ||
                           out_data !== exp_dat[cyc]))) begin
        mismatched++;
        $display("FAIL timeline cyc %0d: got vs=%b hs=%b de=%b rdy=%b row=%0d col=%0d data=%h want vs=%b hs=%b de=%b rdy=%b row=%0d col=%0d data=%h",
                 cyc, out_vsync, out_hsync, out_de, in_ready, out_row, out_col, out_data,
                 exp_vs[cyc], exp_hs[cyc], exp_de[cyc], exp_rdy[cyc], exp_row[cyc], exp_col[cyc], exp_dat[cyc]);
      end
      if (out_vsync) vs_seen++;
    end
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
    cyc++;
    if (cyc >= MAXC - 64) begin
      $display("FAIL cycle_budget: got cyc %0d want < %0d", cyc, MAXC - 64);
      $fatal(1, "cycle budget exhausted");
    end
    in_valid = vpat[cyc];
    in_data  = dpat[cyc];
  endtask

  task automatic ahb_write(input int idx, input logic [31:0] d);
    sl_HSEL = 1; sl_HTRANS = 2'b10; sl_HWRITE = 1; sl_HADDR = 32'(idx << 2);
    tick();
    sl_HSEL = 0; sl_HTRANS = 2'b00; sl_HWRITE = 0; sl_HWDATA = d;
    tick();
  endtask

  task automatic ahb_read(input int idx, output logic [31:0] d);
    sl_HSEL = 1; sl_HTRANS = 2'b11; sl_HWRITE = 0; sl_HADDR = 32'(idx << 2);
    tick();
    sl_HSEL = 0; sl_HTRANS = 2'b00;
    d = out_sl_HRDATA;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic chk_reg(input string name, input int idx, input logic [31:0] want);
    logic [31:0] d;
    ahb_read(idx, d);
    check(name, d, want);
  endtask

  function automatic int max1(input int x);
    return (x < 1) ? 1 : x;
  endfunction

  // Brightness as defined on plain integers: clamp to the channel range
  function automatic logic [DW-1:0] br(input logic [DW-1:0] d);
    logic [DW-1:0] r;
    int c;
    for (int i = 0; i < PPC*3; i++) begin
      c = int'(d[i*PW +: PW]);
      if (br_mode_m == 0) c = (c + br_val_m > 255) ? 255 : c + br_val_m;
      else                c = (c < br_val_m) ? 0 : c - br_val_m;
      r[i*PW +: PW] = PW'(c);
    end
    return r;
  endfunction

  // Lay out one frame starting at VSYNC cycle 'base'; nothing after 'stop' happens
  task automatic plan_frame(input int base, input int stop, output int fin);
    int k, col, rows;
    k = base;
    rows = max1(cfg_h);
    repeat (max1(cfg_v)) begin if (k <= stop) exp_vs[k+LAT] = 1; k++; end
    for (int r = 0; r < rows; r++) begin
      repeat (max1(cfg_hs)) begin if (k <= stop) exp_hs[k+LAT] = 1; k++; end
      col = 0;
      do begin
        while (!vpat[k] && k < MAXC - 8) begin
          if (k <= stop) begin exp_rdy[k] = 1; uf_m = 1; end
          k++;
        end
        if (k <= stop) begin
          exp_rdy[k] = 1;
          exp_de[k+LAT] = 1;
          exp_row[k+LAT] = 12'(r);
          exp_col[k+LAT] = 12'(col);
          exp_dat[k+LAT] = br(dpat[k]);
          if (r == rows - 1 && col + PPC >= cfg_w) begin fcnt_m++; fd_m = 1; end
        end
        col += PPC;
        k++;
      end while (col < cfg_w);
    end
    k += max1(cfg_g);
    fin = k;
  endtask

  task automatic set_cfg(input int w, input int h, input int v, input int hs, input int g);
    cfg_w = w; cfg_h = h; cfg_v = v; cfg_hs = hs; cfg_g = g;
    ahb_write(0, 32'(w)); ahb_write(1, 32'(h)); ahb_write(2, 32'(v));
    ahb_write(3, 32'(hs)); ahb_write(4, 32'(g));
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic run_frame(input int ctrl, output int len);
    int base, fin;
    ahb_write(5, 32'(ctrl | 1));
    base = cyc;
    plan_frame(base, MAXC, fin);
    len = fin - base;
    wait_until(fin + LAT + 1);
  endtask

  task automatic all_valid(input int from, input int n);
    for (int i = from; i < from + n && i < MAXC; i++) vpat[i] = 1;
  endtask

  initial begin
    int len, base, fin1, fin2, fin3, c, vs0;
    logic [31:0] v;
    for (int i = 0; i < MAXC; i++) begin
      vpat[i] = ($urandom_range(99) < 75);
      dpat[i] = DW'({$urandom, $urandom});
    end
    vpat[0] = 0; vpat[1] = 0; vpat[2] = 0; vpat[3] = 0;
    repeat (3) tick();
    HRESETn = 1;
    chk_en = 1;
    tick();

    // Reset state
    check("rst_out_data", 32'(out_data[31:0]), 32'h0);
    check("rst_out_row", 32'(out_row), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("hready", 32'(out_sl_HREADY), 32'h1);
    check("hresp", 32'(out_sl_HRESP), 32'h0);
    chk_reg("rst_width", 0, 32'd768);
    chk_reg("rst_height", 1, 32'd512);
    chk_reg("rst_vsync", 2, 32'd100);
    chk_reg("rst_hsync", 3, 32'd160);
    chk_reg("rst_gap", 4, 32'd200);
    chk_reg("rst_ctrl", 5, 32'd0);
    chk_reg("rst_status", 6, 32'd0);
    chk_reg("rst_fcnt", 7, 32'd0);

    // Register read/write
    for (int i = 0; i < 5; i++) begin
      v = 32'($urandom_range(4095));
      ahb_write(i, v | 32'hF000);
      chk_reg("rw_reg", i, v);
    end
    ahb_write(5, 32'h6);
    chk_reg("rw_ctrl", 5, 32'h6);
    ahb_write(5, 32'h0);
    ahb_write(6, 32'hFFFF_FFFF);
    chk_reg("rw_status_ro", 6, 32'h0);
    ahb_write(7, 32'h1234);
    chk_reg("rw_fcnt_ro", 7, 32'h0);
    chk_reg("rw_idx15", 15, 32'h0);
`ifndef LCD_DRIVE_BR_EN
    ahb_write(9, 32'hFF);
    chk_reg("rw_idx9_absent", 9, 32'h0);
`endif

    // Directed frame: 8x2, vsync 3, hsync 2, gap 4, stream always valid
    set_cfg(8, 2, 3, 2, 4);
    all_valid(cyc, 40);
    vs0 = vs_seen;
    run_frame(0, len);
    check("frame_len", 32'(len), 32'd19);
    check("vsync_cycles", 32'(vs_seen - vs0), 32'd3);
    chk_reg("fcnt_1", 7, 32'd1);
    chk_reg("status_fd", 6, 32'h4);
    ahb_write(6, 32'h4);
    fd_m = 0;
    chk_reg("status_clr", 6, 32'h0);

    // Underflow: three idle stream cycles in the middle of row 0
    all_valid(cyc, 40);
    for (int i = cyc + 8; i < cyc + 11; i++) vpat[i] = 0;
    run_frame(4, len);
    check("uf_frame_len", 32'(len), 32'd22);
    chk_reg("uf_status", 6, 32'h6);
    check("uf_irq", 32'(irq), 32'h1);
    ahb_write(6, 32'h2);
    chk_reg("uf_w1c", 6, 32'h4);
    ahb_write(6, 32'h4);
    check("irq_cleared", 32'(irq), 32'h0);
    uf_m = 0; fd_m = 0;

    // Continuous mode: three frames, start cleared during the third
    ahb_write(5, 32'h7);
    base = cyc;
    plan_frame(base, MAXC, fin1);
    plan_frame(fin1, MAXC, fin2);
    plan_frame(fin2, MAXC, fin3);
    wait_until(fin2 + 2);
    ahb_write(5, 32'h6);
    wait_until(fin3 + LAT + 1);
    chk_reg("cont_fcnt", 7, 32'd5);
    chk_reg("cont_status", 6, {29'd0, fd_m, uf_m, 1'b0});
    ahb_write(6, 32'h6);
    uf_m = 0; fd_m = 0;
    ahb_write(5, 32'h0);

    // Abort while the row 1 / col 4 beat is accepted
    all_valid(cyc, 40);
    ahb_write(5, 32'h1);
    base = cyc;
    c = base + 13;
    plan_frame(base, c, fin1);
    wait_until(c - 1);
    ahb_write(5, 32'h8);
    check("abort_ready", 32'(in_ready), 32'h0);
    chk_reg("abort_fcnt", 7, 32'd5);
    chk_reg("abort_status", 6, 32'h0);
    chk_reg("abort_ctrl", 5, 32'h0);
    run_frame(0, len);
    chk_reg("post_abort_fcnt", 7, 32'd6);
    ahb_write(6, 32'h6);
    uf_m = 0; fd_m = 0;

`ifdef LCD_DRIVE_BR_EN
    // Brightness add then subtract on a fully valid frame
    for (int m = 0; m < 2; m++) begin
      br_mode_m = m; br_val_m = 32'h20;
      ahb_write(8, 32'(m));
      ahb_write(9, 32'h20);
      chk_reg("br_value", 9, 32'h20);
      all_valid(cyc, 40);
      dpat[cyc + 10][7:0] = (m == 0) ? 8'hF0 : 8'h10;
      run_frame(0, len);
    end
    br_mode_m = 0; br_val_m = 0;
    ahb_write(8, 32'h0);
    ahb_write(9, 32'h0);
    ahb_write(6, 32'h6);
    uf_m = 0; fd_m = 0;
`endif

    // Randomised geometry, delays and stream gaps
    for (int t = 0; t < 8; t++) begin
      set_cfg($urandom_range(1, 10), $urandom_range(1, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3));
      run_frame(0, len);
      chk_reg("rand_fcnt", 7, 32'(fcnt_m));
      chk_reg("rand_status", 6, {29'd0, fd_m, uf_m, 1'b0});
      ahb_write(6, 32'h6);
      uf_m = 0; fd_m = 0;
    end

    repeat (3) tick();
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
